// File: rtl/audio_pkg.sv
// Shared constants for the tone synthesiser and its I2S transmitter.
// Holds channel-mode encodings, the mclk tap and the amplitude bound check.
package audio_pkg;

  localparam logic [1:0] CH_STEREO = 2'b00;
  localparam logic [1:0] CH_LEFT   = 2'b01;
  localparam logic [1:0] CH_RIGHT  = 2'b10;
  localparam logic [1:0] CH_ANTI   = 2'b11;

  localparam int MCLK_BIT = 1;

  // Full-scale amplitude must fit in the positive half of a signed word.
  function automatic bit amp_fits(
    input int levels,
    input int step,
    input int w
  );
    return (longint'(levels - 1) * longint'(step))
           < (longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// Left-justified I2S transmitter: free-running divider, frame latch, sdin.
// Ports: clk, rst, left/right sample words in; mclk, sck, lrck, sdin out.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SCK_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic                mclk,
  output logic                sck,
  output logic                lrck,
  output logic                sdin
);

  localparam int BIT_W = $clog2(SAMPLE_W);
  localparam int CNT_W = SCK_LOG2 + BIT_W + 1;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;
  logic                sdin_q;
  logic                wrap;
  logic                sck_fall;
  logic [BIT_W:0]      hi_nx;
  logic [BIT_W-1:0]    idx;
  logic [SAMPLE_W-1:0] word;

  assign cnt_nx   = cnt + 1'b1;
  assign wrap     = &cnt;
  assign sck_fall = &cnt[SCK_LOG2-1:0];

  // Low bits are all ones at sck_fall, so the next slot/lrck is hi+1.
  assign hi_nx = cnt[CNT_W-1:SCK_LOG2] + 1'b1;
  assign idx   = BIT_W'(SAMPLE_W - 1) - hi_nx[BIT_W-1:0];

  // At the wrap the latch is loading in the same edge, so the first
  // left bit is taken straight from the incoming word.
  always_comb begin
    word = left_q;
    if (wrap)
      word = left;
    else if (hi_nx[BIT_W])
      word = right_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      left_q  <= '0;
      right_q <= '0;
      sdin_q  <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      if (wrap) begin
        left_q  <= left;
        right_q <= right;
      end
      if (sck_fall)
        sdin_q <= word[idx];
    end
  end

  assign mclk = cnt[MCLK_BIT];
  assign sck  = cnt[SCK_LOG2-1];
  assign lrck = cnt[CNT_W-1];
  assign sdin = sdin_q;

endmodule

// File: rtl/i2s_tone_synth.sv
// Square-wave tone synth with saturating volume, mute and channel modes.
// Ports: clk, rst, note_div, vol_up/down, mute, ch_mode; vol_level, audio_*.
module i2s_tone_synth
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int DIV_W      = 22,
  parameter int VOL_LEVELS = 16,
  parameter int VOL_INIT   = 15,
  parameter int VOL_STEP   = 1280,
  parameter int SCK_LOG2   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              note_div,
  input  logic                          vol_up,
  input  logic                          vol_down,
  input  logic                          mute,
  input  logic [1:0]                    ch_mode,
  output logic [$clog2(VOL_LEVELS)-1:0] vol_level,
  output logic                          audio_mclk,
  output logic                          audio_sck,
  output logic                          audio_lrck,
  output logic                          audio_sdin
);

  localparam int VOL_W = $clog2(VOL_LEVELS);
  localparam logic [VOL_W-1:0] VOL_MAX =
    VOL_W'(VOL_LEVELS - 1);
  localparam bit AMP_OK =
    amp_fits(VOL_LEVELS, VOL_STEP, SAMPLE_W);

  if (!AMP_OK) begin : g_amp_check
    $error("VOL_STEP too large for SAMPLE_W");
  end

  logic [DIV_W-1:0]    note_q;
  logic [DIV_W-1:0]    half;
  logic [DIV_W-1:0]    tc;
  logic                phase;
  logic                silent;
  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] tone;
  logic [SAMPLE_W-1:0] left_s;
  logic [SAMPLE_W-1:0] right_s;

  always_ff @(posedge clk) begin
    if (rst)
      vol_level <= VOL_W'(VOL_INIT);
    else if (vol_up && !vol_down
             && vol_level != VOL_MAX)
      vol_level <= vol_level + 1'b1;
    else if (vol_down && !vol_up
             && vol_level != '0)
      vol_level <= vol_level - 1'b1;
  end

  assign half   = note_div >> 1;
  assign silent = note_div < DIV_W'(2);

  // A new note restarts the square from phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_q <= '0;
      tc     <= '0;
      phase  <= 1'b0;
    end else begin
      note_q <= note_div;
      if (silent || note_div != note_q) begin
        tc    <= '0;
        phase <= 1'b0;
      end else if (tc == half - 1'b1) begin
        tc    <= '0;
        phase <= ~phase;
      end else begin
        tc <= tc + 1'b1;
      end
    end
  end

  assign amp = SAMPLE_W'(32'(vol_level) * 32'(VOL_STEP));

  always_comb begin
    tone = phase ? amp : -amp;
    if (mute || silent)
      tone = '0;
    left_s  = tone;
    right_s = tone;
    unique case (ch_mode)
      CH_STEREO: ;
      CH_LEFT:   right_s = '0;
      CH_RIGHT:  left_s  = '0;
      CH_ANTI:   right_s = -tone;
    endcase
  end

  i2s_tx #(
    .SAMPLE_W(SAMPLE_W),
    .SCK_LOG2(SCK_LOG2)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .left (left_s),
    .right(right_s),
    .mclk (audio_mclk),
    .sck  (audio_sck),
    .lrck (audio_lrck),
    .sdin (audio_sdin)
  );

endmodule

// File: tb/tb_i2s_tone_synth.sv
// Directed bench for i2s_tone_synth: decodes frames from the pins and
// compares them with hand-computed words.
module tb_i2s_tone_synth;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] note_div = '0;
  logic        vol_up = 1'b0;
  logic        vol_down = 1'b0;
  logic        mute = 1'b0;
  logic [1:0]  ch_mode = 2'b00;
  logic [3:0]  vol_level;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;

  int total = 0;
  int passed = 0;

  i2s_tone_synth dut (
    .clk       (clk),
    .rst       (rst),
    .note_div  (note_div),
    .vol_up    (vol_up),
    .vol_down  (vol_down),
    .mute      (mute),
    .ch_mode   (ch_mode),
    .vol_level (vol_level),
    .audio_mclk(audio_mclk),
    .audio_sck (audio_sck),
    .audio_lrck(audio_lrck),
    .audio_sdin(audio_sdin)
  );

  always #5 clk = ~clk;

  task automatic wait_frame(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = audio_lrck;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (prev && !audio_lrck) begin
        ok = 1'b1;
        return;
      end
      prev = audio_lrck;
    end
  endtask

  // Called at the negedge where cnt = 0; returns at cnt = 511.
  task automatic capture(
    input  int          down_at,
    output logic [15:0] l,
    output logic [15:0] r,
    output bit          tim_ok
  );
    logic last;
    l = '0;
    r = '0;
    tim_ok = 1'b1;
    last = audio_sdin;
    for (int k = 0; k < 512; k++) begin
      if (k > 0) @(negedge clk);
      if (k == down_at) vol_down = 1'b1;
      else if (k == down_at + 1) vol_down = 1'b0;
      if (audio_lrck !== (k >= 256) ||
          audio_sck !== k[3] ||
          audio_mclk !== k[1])
        tim_ok = 1'b0;
      if ((k % 16) != 0 && audio_sdin !== last)
        tim_ok = 1'b0;
      last = audio_sdin;
      if ((k % 16) == 8) begin
        if (k < 256) l = {l[14:0], audio_sdin};
        else         r = {r[14:0], audio_sdin};
      end
    end
  endtask

  task automatic pulse(input bit up, input bit dn);
    @(negedge clk);
    vol_up = up;
    vol_down = dn;
    @(negedge clk);
    vol_up = 1'b0;
    vol_down = 1'b0;
  endtask

  task automatic get_frame(
    input  string       name,
    output logic [15:0] l,
    output logic [15:0] r
  );
    bit ok;
    bit tim;
    wait_frame(ok);
    total++;
    if (!ok) $display("FAIL %s frame_wait got timeout want lrck fall", name);
    else passed++;
    capture(-1, l, r, tim);
    total++;
    if (!tim) $display("FAIL %s timing got bad want lrck/sck/mclk/sdin pattern", name);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0)
      $display("FAIL reset_outputs got %b want 0000",
               {audio_mclk, audio_sck, audio_lrck, audio_sdin});
    else passed++;
    total++;
    if (vol_level !== 4'd15)
      $display("FAIL reset_vol got %0d want 15", vol_level);
    else passed++;
  endtask

  task automatic test_silence();
    logic [15:0] l, r;
    bit tim;
    rst = 1'b0;
    capture(-1, l, r, tim);
    total++;
    if (!tim || l !== 16'h0 || r !== 16'h0)
      $display("FAIL silence_f0 got %h/%h tim=%0b want 0000/0000 tim=1", l, r, tim);
    else passed++;
    get_frame("silence_f1", l, r);
    total++;
    if (l !== 16'h0 || r !== 16'h0)
      $display("FAIL silence_f1 got %h/%h want 0000/0000", l, r);
    else passed++;
  endtask

  task automatic test_tone();
    logic [15:0] l, r;
    bit pos = 0;
    bit neg = 0;
    note_div = 22'd1000;
    for (int f = 0; f < 4; f++) begin
      get_frame("tone", l, r);
      total++;
      if ((l !== 16'h4B00 && l !== 16'hB500) || r !== l)
        $display("FAIL tone_word got %h/%h want 4B00 or B500 on both", l, r);
      else passed++;
      if (l === 16'h4B00) pos = 1;
      if (l === 16'hB500) neg = 1;
    end
    total++;
    if (!(pos && neg))
      $display("FAIL tone_alt got pos=%0b neg=%0b want both 1", pos, neg);
    else passed++;
  endtask

  task automatic test_volume();
    logic [15:0] l, r;
    for (int i = 0; i < 20; i++) pulse(1, 0);
    total++;
    if (vol_level !== 4'd15)
      $display("FAIL vol_sat_hi got %0d want 15", vol_level);
    else passed++;
    for (int i = 0; i < 16; i++) pulse(0, 1);
    total++;
    if (vol_level !== 4'd0)
      $display("FAIL vol_sat_lo got %0d want 0", vol_level);
    else passed++;
    get_frame("vol0", l, r);
    total++;
    if (l !== 16'h0 || r !== 16'h0)
      $display("FAIL vol0_word got %h/%h want 0000/0000", l, r);
    else passed++;
    pulse(1, 1);
    total++;
    if (vol_level !== 4'd0)
      $display("FAIL vol_both0 got %0d want 0", vol_level);
    else passed++;
    pulse(1, 0);
    pulse(1, 1);
    total++;
    if (vol_level !== 4'd1)
      $display("FAIL vol_both1 got %0d want 1", vol_level);
    else passed++;
    for (int i = 0; i < 14; i++) pulse(1, 0);
    total++;
    if (vol_level !== 4'd15)
      $display("FAIL vol_restore got %0d want 15", vol_level);
    else passed++;
  endtask

  task automatic test_vol_mid_word();
    logic [15:0] l, r;
    bit ok;
    bit tim;
    wait_frame(ok);
    capture(100, l, r, tim);
    total++;
    if (!ok || !tim || (l !== 16'h4B00 && l !== 16'hB500) || r !== l)
      $display("FAIL vol_mid_cur got %h/%h want 4B00 or B500 on both", l, r);
    else passed++;
    get_frame("vol_mid_next", l, r);
    total++;
    if ((l !== 16'h4600 && l !== 16'hBA00) || r !== l)
      $display("FAIL vol_mid_next got %h/%h want 4600 or BA00 on both", l, r);
    else passed++;
    total++;
    if (vol_level !== 4'd14)
      $display("FAIL vol_mid_lvl got %0d want 14", vol_level);
    else passed++;
    pulse(1, 0);
  endtask

  task automatic test_channels();
    logic [15:0] l, r, er;
    ch_mode = 2'b11;
    get_frame("anti", l, r);
    er = (l === 16'h4B00) ? 16'hB500 : 16'h4B00;
    total++;
    if ((l !== 16'h4B00 && l !== 16'hB500) || r !== er)
      $display("FAIL anti got %h/%h want %h/%h", l, r, l, er);
    else passed++;
    ch_mode = 2'b01;
    get_frame("left_only", l, r);
    total++;
    if ((l !== 16'h4B00 && l !== 16'hB500) || r !== 16'h0)
      $display("FAIL left_only got %h/%h want 4B00|B500/0000", l, r);
    else passed++;
    ch_mode = 2'b10;
    get_frame("right_only", l, r);
    total++;
    if (l !== 16'h0 || (r !== 16'h4B00 && r !== 16'hB500))
      $display("FAIL right_only got %h/%h want 0000/4B00|B500", l, r);
    else passed++;
    ch_mode = 2'b00;
    mute = 1'b1;
    get_frame("mute", l, r);
    total++;
    if (l !== 16'h0 || r !== 16'h0)
      $display("FAIL mute got %h/%h want 0000/0000", l, r);
    else passed++;
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] l, r;
    bit ok;
    bit tim;
    pulse(0, 1);
    wait_frame(ok);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0)
      $display("FAIL rst_mid_out got %b want 0000",
               {audio_mclk, audio_sck, audio_lrck, audio_sdin});
    else passed++;
    total++;
    if (vol_level !== 4'd15)
      $display("FAIL rst_mid_vol got %0d want 15", vol_level);
    else passed++;
    rst = 1'b0;
    capture(-1, l, r, tim);
    total++;
    if (!ok || !tim || l !== 16'h0 || r !== 16'h0)
      $display("FAIL rst_mid_f0 got %h/%h tim=%0b want 0000/0000 tim=1", l, r, tim);
    else passed++;
    get_frame("rst_mid_f1", l, r);
    total++;
    if ((l !== 16'h4B00 && l !== 16'hB500) || r !== l)
      $display("FAIL rst_mid_f1 got %h/%h want 4B00 or B500 on both", l, r);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_silence();
    test_tone();
    test_volume();
    test_vol_mid_word();
    test_channels();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
